// File: rtl/bp_me_cache_dma_arbiter.sv
// bp_me_cache_dma_arbiter
// Shares one DRAM command/response link among several L2 slices. A header
// arbiter grants one slice per command, a write locks the data channel to that
// slice for a whole block, and an in-order tag FIFO steers read-response beats
// back to the slice that issued the command.
// Optional feature: define BP_ME_CACHE_DMA_ARB_FIXED_PRIO_EN for fixed-priority
// arbitration (lowest slice index wins). Round-robin is used otherwise.
// tag_els_p is expected to be a power of two, at least 2.
module bp_me_cache_dma_arbiter #(
  parameter int num_slices_p   = 2,
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64,
  parameter int block_beats_p  = 8,
  parameter int tag_els_p      = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_slices_p*header_width_p-1:0] slice_cmd_header_i,
  input  logic [num_slices_p-1:0]                slice_cmd_header_v_i,
  input  logic [num_slices_p-1:0]                slice_cmd_wr_i,
  output logic [num_slices_p-1:0]                slice_cmd_header_yumi_o,
  input  logic [num_slices_p*data_width_p-1:0]   slice_cmd_data_i,
  input  logic [num_slices_p-1:0]                slice_cmd_data_v_i,
  output logic [num_slices_p-1:0]                slice_cmd_data_yumi_o,
  output logic [header_width_p-1:0]              mem_cmd_header_o,
  output logic                                   mem_cmd_header_v_o,
  input  logic                                   mem_cmd_header_yumi_i,
  output logic [data_width_p-1:0]                mem_cmd_data_o,
  output logic                                   mem_cmd_data_v_o,
  input  logic                                   mem_cmd_data_yumi_i,
  input  logic                                   mem_resp_header_v_i,
  output logic                                   mem_resp_header_ready_o,
  input  logic [data_width_p-1:0]                mem_resp_data_i,
  input  logic                                   mem_resp_data_v_i,
  output logic                                   mem_resp_data_ready_o,
  output logic [data_width_p-1:0]                slice_resp_data_o,
  output logic [num_slices_p-1:0]                slice_resp_data_v_o,
  input  logic [num_slices_p-1:0]                slice_resp_data_ready_i
);

  localparam int id_w   = $clog2(num_slices_p);
  localparam int cnt_w  = $clog2(block_beats_p);
  localparam int tag_aw = $clog2(tag_els_p);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(block_beats_p - 1);

  typedef enum logic {CMD_IDLE, CMD_DATA}   cmd_state_e;
  typedef enum logic {RESP_IDLE, RESP_DATA} resp_state_e;

  cmd_state_e            cmd_state_r;
  resp_state_e           resp_state_r;
  logic [id_w-1:0]       lock_id_r;
  logic [id_w-1:0]       resp_id_r;
  logic [cnt_w-1:0]      cmd_cnt_r;
  logic [cnt_w-1:0]      resp_cnt_r;

  logic [id_w-1:0]       winner;
  logic                  winner_wr;
  logic                  any_v;
  logic                  push;
  logic                  pop;
  logic                  cmd_beat;
  logic                  resp_beat;

  // Tag FIFO: each entry is {slice id, is_write}
  logic [id_w:0]         tag_mem [tag_els_p];
  logic [tag_aw:0]       wptr_r;
  logic [tag_aw:0]       rptr_r;
  logic                  full;
  logic                  empty;
  logic [id_w:0]         head;

  logic [header_width_p-1:0] hdr_arr  [num_slices_p];
  logic [data_width_p-1:0]   data_arr [num_slices_p];

  for (genvar g = 0; g < num_slices_p; g++) begin : g_unpack
    assign hdr_arr[g]  = slice_cmd_header_i[g*header_width_p +: header_width_p];
    assign data_arr[g] = slice_cmd_data_i[g*data_width_p +: data_width_p];
  end

  // Index of the lowest set bit; 0 when none is set
  function automatic logic [id_w-1:0] lowest_set(input logic [num_slices_p-1:0] v);
    lowest_set = '0;
    for (int i = num_slices_p - 1; i >= 0; i--) begin
      if (v[id_w'(i)]) lowest_set = id_w'(i);
    end
  endfunction

  assign any_v = |slice_cmd_header_v_i;

`ifdef BP_ME_CACHE_DMA_ARB_FIXED_PRIO_EN
  assign winner = lowest_set(slice_cmd_header_v_i);
`else
  logic [id_w-1:0]         rr_r;
  logic [num_slices_p-1:0] hi_mask;
  logic [num_slices_p-1:0] hi_req;

  // Requests at or above the round-robin pointer take precedence, then wrap
  assign hi_mask = ~((num_slices_p'(1) << rr_r) - num_slices_p'(1));
  assign hi_req  = slice_cmd_header_v_i & hi_mask;
  assign winner  = (|hi_req) ? lowest_set(hi_req) : lowest_set(slice_cmd_header_v_i);

  // Advance the pointer past each granted slice
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_r <= '0;
    end else if (push) begin
      rr_r <= (winner == id_w'(num_slices_p - 1)) ? '0 : winner + 1'b1;
    end
  end
`endif

  assign winner_wr = slice_cmd_wr_i[winner];

  // Header and data channels are pure pass-through; reset masks the header
  // valid because a live slice request would otherwise leak through.
  assign mem_cmd_header_v_o = reset_n_i && (cmd_state_r == CMD_IDLE) && any_v && !full;
  assign mem_cmd_header_o   = hdr_arr[winner];
  assign push               = mem_cmd_header_v_o && mem_cmd_header_yumi_i;

  assign mem_cmd_data_o     = data_arr[lock_id_r];
  assign mem_cmd_data_v_o   = (cmd_state_r == CMD_DATA) && slice_cmd_data_v_i[lock_id_r];
  assign cmd_beat           = mem_cmd_data_v_o && mem_cmd_data_yumi_i;

  // Route the memory yumis back to the granted / locked slice only
  always_comb begin
    slice_cmd_header_yumi_o = '0;
    slice_cmd_data_yumi_o   = '0;
    if (push)     slice_cmd_header_yumi_o[winner] = 1'b1;
    if (cmd_beat) slice_cmd_data_yumi_o[lock_id_r] = 1'b1;
  end

  // Command FSM: grant headers in idle, stream a full write block when locked
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_state_r <= CMD_IDLE;
      lock_id_r   <= '0;
      cmd_cnt_r   <= '0;
    end else begin
      case (cmd_state_r)
        CMD_IDLE: begin
          if (push && winner_wr) begin
            lock_id_r   <= winner;
            cmd_cnt_r   <= '0;
            cmd_state_r <= CMD_DATA;
          end
        end
        CMD_DATA: begin
          if (cmd_beat) begin
            cmd_cnt_r <= cmd_cnt_r + 1'b1;
            if (cmd_cnt_r == cnt_last) cmd_state_r <= CMD_IDLE;
          end
        end
        default: cmd_state_r <= CMD_IDLE;
      endcase
    end
  end

  // Full compares registered pointers, so a same-cycle pop never frees a slot
  assign full  = (wptr_r[tag_aw] != rptr_r[tag_aw]) &&
                 (wptr_r[tag_aw-1:0] == rptr_r[tag_aw-1:0]);
  assign empty = (wptr_r == rptr_r);
  assign head  = tag_mem[rptr_r[tag_aw-1:0]];

  // Tag storage holds data only; validity is tracked by the pointers
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wptr_r[tag_aw-1:0]] <= {winner, winner_wr};
  end

  // Tag FIFO pointers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + 1'b1;
      if (pop)  rptr_r <= rptr_r + 1'b1;
    end
  end

  assign mem_resp_header_ready_o = (resp_state_r == RESP_IDLE) && !empty;
  assign pop                     = mem_resp_header_ready_o && mem_resp_header_v_i;
  assign mem_resp_data_ready_o   = (resp_state_r == RESP_DATA) && slice_resp_data_ready_i[resp_id_r];
  assign resp_beat               = mem_resp_data_v_i && mem_resp_data_ready_o;
  assign slice_resp_data_o       = mem_resp_data_i;

  // One-hot response valid toward the slice owning the current read block
  always_comb begin
    slice_resp_data_v_o = '0;
    if (resp_state_r == RESP_DATA) slice_resp_data_v_o[resp_id_r] = mem_resp_data_v_i;
  end

  // Response FSM: pop tags in issue order, stream read blocks to their owner
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_state_r <= RESP_IDLE;
      resp_id_r    <= '0;
      resp_cnt_r   <= '0;
    end else begin
      case (resp_state_r)
        RESP_IDLE: begin
          if (pop && !head[0]) begin
            resp_id_r    <= head[id_w:1];
            resp_cnt_r   <= '0;
            resp_state_r <= RESP_DATA;
          end
        end
        RESP_DATA: begin
          if (resp_beat) begin
            resp_cnt_r <= resp_cnt_r + 1'b1;
            if (resp_cnt_r == cnt_last) resp_state_r <= RESP_IDLE;
          end
        end
        default: resp_state_r <= RESP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_me_cache_dma_arbiter.sv
// Testbench for bp_me_cache_dma_arbiter (default round-robin build).
module tb_bp_me_cache_dma_arbiter;

  localparam int N  = 2;
  localparam int HW = 64;
  localparam int DW = 64;
  localparam int BB = 8;
  localparam int TE = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic [HW-1:0] hdr [N];
  logic [DW-1:0] dat [N];
  logic [N-1:0]  hv, wr, dv, rdy;
  logic          myumi, dyumi, rhv, rdv;
  logic [DW-1:0] rdata;

  logic [N-1:0]  hy_o, dy_o, rv_o;
  logic [HW-1:0] hdr_o;
  logic [DW-1:0] dout_o, rdata_o;
  logic          hv_o, dv_o, rhr_o, rdr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_me_cache_dma_arbiter #(
    .num_slices_p(N), .header_width_p(HW), .data_width_p(DW),
    .block_beats_p(BB), .tag_els_p(TE)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .slice_cmd_header_i({hdr[1], hdr[0]}),
    .slice_cmd_header_v_i(hv),
    .slice_cmd_wr_i(wr),
    .slice_cmd_header_yumi_o(hy_o),
    .slice_cmd_data_i({dat[1], dat[0]}),
    .slice_cmd_data_v_i(dv),
    .slice_cmd_data_yumi_o(dy_o),
    .mem_cmd_header_o(hdr_o),
    .mem_cmd_header_v_o(hv_o),
    .mem_cmd_header_yumi_i(myumi),
    .mem_cmd_data_o(dout_o),
    .mem_cmd_data_v_o(dv_o),
    .mem_cmd_data_yumi_i(dyumi),
    .mem_resp_header_v_i(rhv),
    .mem_resp_header_ready_o(rhr_o),
    .mem_resp_data_i(rdata),
    .mem_resp_data_v_i(rdv),
    .mem_resp_data_ready_o(rdr_o),
    .slice_resp_data_o(rdata_o),
    .slice_resp_data_v_o(rv_o),
    .slice_resp_data_ready_i(rdy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    hv = '0; wr = '0; dv = '0; rdy = '0;
    myumi = 1'b0; dyumi = 1'b0; rhv = 1'b0; rdv = 1'b0; rdata = '0;
    hdr[0] = 64'hA0; hdr[1] = 64'hB1; dat[0] = '0; dat[1] = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
  endtask

  // Deliver one read block to slice id; its ready toggles, the other slice's is inverted
  task automatic stream(input int id);
    int n = 0;
    int k = 0;
    logic own;
    while (n < BB && k < 40) begin
      own = (k % 2 == 0);
      rdv = 1'b1;
      rdata = {$urandom, $urandom};
      rdy = (id == 0) ? {~own, own} : {own, ~own};
      @(negedge clk);
      chk("resp_v_onehot", rv_o, 64'(2'b01 << id));
      chk("resp_ready_follow", rdr_o, own);
      chk("resp_data_bcast", rdata_o, rdata);
      if (own) n++;
      next_cycle();
      k++;
    end
    if (n < BB) chk("resp_stream_timeout", n, BB);
    rdy = 2'b11;
    @(negedge clk);
    chk("resp_done_v", rv_o, 0);
    next_cycle();
    rdv = 1'b0;
  endtask

  task automatic pop_hdr();
    rhv = 1'b1;
    @(negedge clk);
    chk("resp_hdr_ready", rhr_o, 1);
    next_cycle();
    rhv = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { int id; bit wr; } tag_t;
  tag_t q[$];
  int rr_m, lock_m, left_m, rown_m, rleft_m;
  int e_win;
  logic e_hv, e_dv, e_rhr, e_rdr;
  logic [N-1:0] e_hy, e_dy, e_rv, last_hy;

  task automatic model_reset();
    q.delete();
    rr_m = 0; lock_m = -1; left_m = 0; rown_m = -1; rleft_m = 0;
    last_hy = '0;
  endtask

  // Outputs that do not depend on the memory yumis
  task automatic model_pre();
    int s;
    e_win = -1;
    if (lock_m < 0) begin
      for (int k = 0; k < N; k++) begin
        s = (rr_m + k) % N;
        if (hv[1'(s)] && e_win < 0) e_win = s;
      end
    end
    e_hv  = (lock_m < 0) && (e_win >= 0) && (q.size() < TE);
    e_dv  = (lock_m >= 0) && dv[1'(lock_m)];
    e_rhr = (rown_m < 0) && (q.size() > 0);
    e_rdr = (rown_m >= 0) && rdy[1'(rown_m)];
    e_rv  = (rown_m >= 0 && rdv) ? N'(1 << rown_m) : '0;
  endtask

  task automatic model_post();
    e_hy = (e_hv && myumi) ? N'(1 << e_win) : '0;
    e_dy = (e_dv && dyumi) ? N'(1 << lock_m) : '0;
  endtask

  task automatic model_seq();
    bit had_lock = (lock_m >= 0);
    bit had_resp = (rown_m >= 0);
    tag_t t;
    if (e_rhr && rhv) begin
      t = q.pop_front();
      if (!t.wr) begin rown_m = t.id; rleft_m = BB; end
    end
    if (e_hv && myumi) begin
      t.id = e_win;
      t.wr = wr[1'(e_win)];
      q.push_back(t);
      rr_m = (e_win + 1) % N;
      if (t.wr) begin lock_m = e_win; left_m = BB; end
    end
    if (had_lock && e_dv && dyumi) begin
      left_m--;
      if (left_m == 0) lock_m = -1;
    end
    if (had_resp && rdv && e_rdr) begin
      rleft_m--;
      if (rleft_m == 0) rown_m = -1;
    end
    last_hy = e_hy;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [1:0]  v;
    logic        yumi;
    logic        exp_hv;
    logic [63:0] exp_hdr;
    logic [1:0]  exp_hy;
    logic        exp_rhr;
  } vec_t;
  vec_t vt [8];

  initial begin
    vt[0] = '{2'b00, 1'b0, 1'b0, 64'h0,  2'b00, 1'b0};
    vt[1] = '{2'b11, 1'b0, 1'b1, 64'hA0, 2'b00, 1'b0};
    vt[2] = '{2'b11, 1'b1, 1'b1, 64'hA0, 2'b01, 1'b0};
    vt[3] = '{2'b11, 1'b0, 1'b1, 64'hB1, 2'b00, 1'b1};
    vt[4] = '{2'b11, 1'b1, 1'b1, 64'hB1, 2'b10, 1'b1};
    vt[5] = '{2'b10, 1'b1, 1'b1, 64'hB1, 2'b10, 1'b1};
    vt[6] = '{2'b01, 1'b1, 1'b1, 64'hA0, 2'b01, 1'b1};
    vt[7] = '{2'b11, 1'b1, 1'b0, 64'h0,  2'b00, 1'b1};

    // Reset: every valid/yumi/ready low even with all inputs active
    clear_inputs();
    reset_n = 1'b0;
    hv = 2'b11; myumi = 1'b1; dv = 2'b11; dyumi = 1'b1;
    rhv = 1'b1; rdv = 1'b1; rdy = 2'b11;
    @(negedge clk);
    chk("rst_hdr_v", hv_o, 0);
    chk("rst_hdr_yumi", hy_o, 0);
    chk("rst_data_v", dv_o, 0);
    chk("rst_data_yumi", dy_o, 0);
    chk("rst_resp_hdr_ready", rhr_o, 0);
    chk("rst_resp_data_ready", rdr_o, 0);
    chk("rst_resp_v", rv_o, 0);
    next_cycle();
    clear_inputs();
    reset_n = 1'b1;

    // Round-robin grants filling the tag FIFO (0,1,1,0)
    for (int i = 0; i < 8; i++) begin
      hv = vt[i].v;
      myumi = vt[i].yumi;
      @(negedge clk);
      chk($sformatf("vec%0d_hdr_v", i), hv_o, vt[i].exp_hv);
      if (vt[i].exp_hv) chk($sformatf("vec%0d_hdr", i), hdr_o, vt[i].exp_hdr);
      chk($sformatf("vec%0d_hdr_yumi", i), hy_o, vt[i].exp_hy);
      chk($sformatf("vec%0d_resp_hdr_ready", i), rhr_o, vt[i].exp_rhr);
      next_cycle();
    end

    // Full FIFO: a pop in the same cycle does not free the push
    hv = 2'b11; myumi = 1'b1; rhv = 1'b1;
    @(negedge clk);
    chk("full_pop_blocks_push", hv_o, 0);
    chk("full_pop_ready", rhr_o, 1);
    next_cycle();
    myumi = 1'b0; rhv = 1'b0;
    @(negedge clk);
    chk("after_pop_hdr_v", hv_o, 1);
    chk("after_pop_rr_hdr", hdr_o, 64'hB1);
    chk("resp_busy_no_hdr", rhr_o, 0);
    next_cycle();
    hv = 2'b00;
    stream(0);
    pop_hdr(); stream(1);
    pop_hdr(); stream(1);
    pop_hdr(); stream(0);
    @(negedge clk);
    chk("fifo_drained", rhr_o, 0);
    next_cycle();

    // Write block from slice 1 locks the data channel against slice 0's read
    do_reset();
    hv = 2'b10; wr = 2'b10; myumi = 1'b1;
    @(negedge clk);
    chk("wr_grant", hy_o, 2'b10);
    next_cycle();
    hv = 2'b01; wr = 2'b00; dv = 2'b11; dyumi = 1'b1;
    for (int b = 0; b < BB; b++) begin
      dat[0] = {$urandom, $urandom};
      dat[1] = {$urandom, $urandom};
      @(negedge clk);
      chk("wr_no_hdr_v", hv_o, 0);
      chk("wr_no_hdr_yumi", hy_o, 0);
      chk("wr_data_v", dv_o, 1);
      chk("wr_data", dout_o, dat[1]);
      chk("wr_data_yumi", dy_o, 2'b10);
      next_cycle();
    end
    dv = 2'b00; dyumi = 1'b0;
    @(negedge clk);
    chk("post_wr_hdr_v", hv_o, 1);
    chk("post_wr_hdr", hdr_o, 64'hA0);
    chk("post_wr_yumi", hy_o, 2'b01);
    next_cycle();
    hv = 2'b00; myumi = 1'b0;
    // Write response is header-only, then slice 0's read block follows
    rdv = 1'b1; rdy = 2'b11;
    pop_hdr();
    @(negedge clk);
    chk("wr_resp_no_beats", rv_o, 0);
    chk("wr_resp_next_hdr", rhr_o, 1);
    next_cycle();
    pop_hdr();
    stream(0);

    // Reset in the middle of a write burst
    hv = 2'b10; wr = 2'b10; myumi = 1'b1;
    next_cycle();
    hv = 2'b01; wr = 2'b00; dv = 2'b10; dyumi = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_data_v", dv_o, 0);
    chk("midrst_data_yumi", dy_o, 0);
    chk("midrst_hdr_v", hv_o, 0);
    chk("midrst_hdr_yumi", hy_o, 0);
    chk("midrst_resp_ready", rhr_o, 0);
    next_cycle();
    reset_n = 1'b1; dv = 2'b00; dyumi = 1'b0;
    @(negedge clk);
    chk("postrst_fifo_empty", rhr_o, 0);
    chk("postrst_grant", hy_o, 2'b01);
    next_cycle();
    hv = 2'b00; myumi = 1'b0;
    @(negedge clk);
    chk("postrst_one_tag", rhr_o, 1);
    next_cycle();

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!hv[1'(s)] || last_hy[1'(s)]) begin
          hv[1'(s)] = ($urandom_range(0, 99) < 60);
          wr[1'(s)] = ($urandom_range(0, 2) == 0);
          hdr[s] = {$urandom, $urandom};
        end
        dv[1'(s)]  = ($urandom_range(0, 3) != 0);
        dat[s]     = {$urandom, $urandom};
        rdy[1'(s)] = ($urandom_range(0, 3) != 0);
      end
      rhv = ($urandom_range(0, 2) == 0);
      rdv = ($urandom_range(0, 3) != 0);
      rdata = {$urandom, $urandom};
      model_pre();
      myumi = e_hv && ($urandom_range(0, 3) != 0);
      dyumi = e_dv && ($urandom_range(0, 3) != 0);
      model_post();
      @(negedge clk);
      chk("rnd_hdr_v", hv_o, e_hv);
      if (e_hv) chk("rnd_hdr", hdr_o, hdr[1'(e_win)]);
      chk("rnd_hdr_yumi", hy_o, e_hy);
      chk("rnd_data_v", dv_o, e_dv);
      if (e_dv) chk("rnd_data", dout_o, dat[1'(lock_m)]);
      chk("rnd_data_yumi", dy_o, e_dy);
      chk("rnd_resp_hdr_ready", rhr_o, e_rhr);
      chk("rnd_resp_data_ready", rdr_o, e_rdr);
      chk("rnd_resp_v", rv_o, e_rv);
      chk("rnd_resp_data", rdata_o, rdata);
      model_seq();
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
